// File: rtl/arith_test_sequencer.sv
// Purpose: issues operand reads interleaved over LANES banks and replays them LATENCY cycles later as result writes (optional feature macro: ATS_STALL_EN).
// Latency: r_en one cycle after start acceptance; w_* trails r_* by exactly LATENCY cycles; done one cycle after the last w_en.
// Backpressure: with ATS_STALL_EN, stall pauses issue in ISSUE only; start is ignored while a run is in progress.
module arith_test_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int LANES      = 2,
    parameter int LATENCY    = 5,
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int NW        = ADDR_WIDTH + LW + 1
) (
    input  logic                  pll_clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NW-1:0]         num_vectors,
`ifdef ATS_STALL_EN
    input  logic                  stall,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  r_en,
    output logic [LW-1:0]         r_lane,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  w_en,
    output logic [LW-1:0]         w_lane,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [31:0]           cycle_count
);

    localparam int LB = $clog2(LANES);
    localparam int DW = $clog2(LATENCY + 1);
    localparam logic [NW-1:0] MAX_VEC = NW'(LANES) << ADDR_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic                  en;
        logic [LW-1:0]         lane;
        logic [ADDR_WIDTH-1:0] addr;
    } port_t;

    logic [1:0]      state_q;
    logic [NW-1:0]   idx_q;
    logic [NW-1:0]   nv_q;
    logic [DW-1:0]   drain_q;
    logic [LW-1:0]   idx_lane;
    logic [ADDR_WIDTH-1:0] idx_addr;
    logic            stall_act;
    logic            abort_act;
    port_t           pipe_q [LATENCY];

`ifdef ATS_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    // Abort only matters once a run has been accepted; in IDLE it is a no-op.
    assign abort_act = abort && (state_q != IDLE);

    generate
        if (LANES == 1) begin : g_one_lane
            assign idx_lane = '0;
            assign idx_addr = idx_q[ADDR_WIDTH-1:0];
        end else begin : g_multi_lane
            assign idx_lane = idx_q[LW-1:0];
            assign idx_addr = idx_q[LB +: ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            nv_q        <= '0;
            drain_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            r_en        <= 1'b0;
            r_lane      <= '0;
            r_addr      <= '0;
            cycle_count <= '0;
        end else if (abort_act) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b1;
            r_en    <= 1'b0;
            r_lane  <= '0;
            r_addr  <= '0;
        end else begin
            done   <= 1'b0;
            r_en   <= 1'b0;
            r_lane <= '0;
            r_addr <= '0;
            if (busy && (cycle_count != 32'hFFFF_FFFF))
                cycle_count <= cycle_count + 32'd1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        aborted     <= 1'b0;
                        cycle_count <= '0;
                        idx_q       <= '0;
                        drain_q     <= '0;
                        if (num_vectors == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            nv_q    <= (num_vectors > MAX_VEC) ? MAX_VEC : num_vectors;
                        end
                    end
                end
                ISSUE: begin
                    busy <= 1'b1;
                    if (!stall_act) begin
                        r_en   <= 1'b1;
                        r_lane <= idx_lane;
                        r_addr <= idx_addr;
                        idx_q  <= idx_q + NW'(1);
                        if (idx_q == nv_q - NW'(1))
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last read reaches the write port LATENCY edges after ISSUE ends.
                    busy <= 1'b1;
                    if (drain_q == DW'(LATENCY - 1))
                        state_q <= DONE;
                    else
                        drain_q <= drain_q + DW'(1);
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write port is the read port shifted LATENCY cycles, gaps included.
    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < LATENCY; k++)
                pipe_q[k] <= '0;
        end else if (abort_act) begin
            for (int k = 0; k < LATENCY; k++)
                pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= {r_en, r_lane, r_addr};
            for (int k = 1; k < LATENCY; k++)
                pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign w_en   = pipe_q[LATENCY-1].en;
    assign w_lane = pipe_q[LATENCY-1].lane;
    assign w_addr = pipe_q[LATENCY-1].addr;

endmodule

// File: tb/tb_arith_test_sequencer.sv
// Scoreboard bench for arith_test_sequencer: expected read/write/done events are queued at
// stimulus time with their cycle stamps and compared against events captured on the falling edge.
module tb_arith_test_sequencer;

    localparam int AW    = 4;
    localparam int LANES = 2;
    localparam int LAT   = 5;
    localparam int LW    = 1;
    localparam int NW    = AW + LW + 1;
    localparam int MAXV  = 32;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic pll_clock = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [NW-1:0] num_vectors = '0;
`ifdef ATS_STALL_EN
    logic stall = 1'b0;
`endif
    logic busy, done, aborted, r_en, w_en;
    logic [LW-1:0] r_lane, w_lane;
    logic [AW-1:0] r_addr, w_addr;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int overlap = 0;
    int rd [3] = '{0, 0, 0};
    string kn [3] = '{"r", "w", "done"};
    ev_t exp_q [3][$];
    ev_t obs_q [3][$];

    arith_test_sequencer #(
        .ADDR_WIDTH(AW),
        .LANES(LANES),
        .LATENCY(LAT)
    ) dut (
        .pll_clock(pll_clock),
        .resetn(resetn),
        .start(start),
        .abort(abort),
        .num_vectors(num_vectors),
`ifdef ATS_STALL_EN
        .stall(stall),
`endif
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .r_en(r_en),
        .r_lane(r_lane),
        .r_addr(r_addr),
        .w_en(w_en),
        .w_lane(w_lane),
        .w_addr(w_addr),
        .cycle_count(cycle_count)
    );

    always #5 pll_clock = ~pll_clock;

    always @(posedge pll_clock) cyc <= cyc + 1;

    // cyc here equals the number of rising edges so far, i.e. the edge that produced these outputs.
    always @(negedge pll_clock) begin
        if (r_en) obs_q[0].push_back(ev_t'{32'(cyc), 32'(r_lane), 32'(r_addr)});
        if (w_en) obs_q[1].push_back(ev_t'{32'(cyc), 32'(w_lane), 32'(w_addr)});
        if (done) obs_q[2].push_back(ev_t'{32'(cyc), cycle_count, 32'd0});
        if (busy) busy_cyc++;
        if (busy && done) overlap++;
    end

    task automatic drive_start(input int n, output int e0);
        @(negedge pll_clock);
        start = 1'b1;
        num_vectors = NW'(n);
        e0 = cyc + 1;
        @(negedge pll_clock);
        start = 1'b0;
    endtask

    // Vectors at index >= stall_at are delayed by stall_len issue cycles.
    function automatic void push_run(input int e0, input int n, input int stall_at, input int stall_len);
        int eff;
        int t;
        eff = (n > MAXV) ? MAXV : n;
        for (int k = 0; k < eff; k++) begin
            t = e0 + 1 + k + ((k >= stall_at) ? stall_len : 0);
            exp_q[0].push_back(ev_t'{32'(t), 32'(k % LANES), 32'(k / LANES)});
            exp_q[1].push_back(ev_t'{32'(t + LAT), 32'(k % LANES), 32'(k / LANES)});
        end
        if (eff == 0)
            exp_q[2].push_back(ev_t'{32'(e0), 32'd0, 32'd0});
        else
            exp_q[2].push_back(ev_t'{32'(e0 + eff + LAT + 1 + stall_len), 32'(eff + LAT + stall_len), 32'd0});
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge pll_clock);
        checks++;
        if ({busy, done, aborted, r_en, w_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, aborted, r_en, w_en});
        end
        checks++;
        if ({r_lane, r_addr, w_lane, w_addr} !== 10'd0) begin
            failures++;
            $display("FAIL reset_ports got=%h want=0", {r_lane, r_addr, w_lane, w_addr});
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", cycle_count);
        end
        resetn = 1'b1;
        repeat (2) @(negedge pll_clock);
        checks++;
        if ({busy, done, r_en, w_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b want=0000", {busy, done, r_en, w_en});
        end
    endtask

    task automatic test_basic(input string tn);
        int e0;
        int b0;
        drive_start(6, e0);
        b0 = busy_cyc;
        push_run(e0, 6, 6, 0);
        repeat (20) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL %s %s_count got=%0d want=%0d", tn, kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL %s %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", tn, kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (busy_cyc - b0 !== 11) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d want=11", tn, busy_cyc - b0);
        end
        checks++;
        if (cycle_count !== 32'd11) begin
            failures++;
            $display("FAIL %s count_held got=%0d want=11", tn, cycle_count);
        end
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL %s busy_done_overlap got=%0d want=0", tn, overlap);
        end
    endtask

    task automatic test_zero();
        int e0;
        int b0;
        b0 = busy_cyc;
        drive_start(0, e0);
        push_run(e0, 0, 0, 0);
        repeat (10) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL zero %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL zero %s[%0d] got=%0d/%0d want=%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, exp_q[q][i].cyc, exp_q[q][i].a);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (busy_cyc - b0 !== 0) begin
            failures++;
            $display("FAIL zero busy_cycles got=%0d want=0", busy_cyc - b0);
        end
    endtask

    task automatic test_abort();
        int e0;
        drive_start(10, e0);
        repeat (2) @(negedge pll_clock);
        abort = 1'b1;
        @(negedge pll_clock);
        abort = 1'b0;
        exp_q[0].push_back(ev_t'{32'(e0 + 1), 32'd0, 32'd0});
        exp_q[0].push_back(ev_t'{32'(e0 + 2), 32'd1, 32'd0});
        checks++;
        if ({busy, done, aborted} !== 3'b001) begin
            failures++;
            $display("FAIL abort_flags got=%b want=001", {busy, done, aborted});
        end
        checks++;
        if (cycle_count !== 32'd1) begin
            failures++;
            $display("FAIL abort_count got=%0d want=1", cycle_count);
        end
        repeat (15) @(negedge pll_clock);
        checks++;
        if ({aborted, cycle_count} !== {1'b1, 32'd1}) begin
            failures++;
            $display("FAIL abort_sticky got=%b/%0d want=1/1", aborted, cycle_count);
        end
        drive_start(3, e0);
        push_run(e0, 3, 3, 0);
        checks++;
        if (aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_cleared got=%b want=0", aborted);
        end
        repeat (15) @(negedge pll_clock);
        abort = 1'b1;
        @(negedge pll_clock);
        abort = 1'b0;
        checks++;
        if ({busy, aborted} !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle got=%b want=00", {busy, aborted});
        end
        @(negedge pll_clock);
        start = 1'b1;
        abort = 1'b1;
        num_vectors = NW'(2);
        e0 = cyc + 1;
        @(negedge pll_clock);
        start = 1'b0;
        abort = 1'b0;
        push_run(e0, 2, 2, 0);
        repeat (15) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL abort %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL abort %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_with_start got=%b want=0", aborted);
        end
    endtask

    task automatic test_restart();
        int e0;
        drive_start(6, e0);
        push_run(e0, 6, 6, 0);
        @(negedge pll_clock);
        start = 1'b1;
        num_vectors = NW'(3);
        @(negedge pll_clock);
        start = 1'b0;
        repeat (5) @(negedge pll_clock);
        start = 1'b1;
        @(negedge pll_clock);
        start = 1'b0;
        repeat (15) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL restart %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL restart %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (cycle_count !== 32'd11) begin
            failures++;
            $display("FAIL restart_count got=%0d want=11", cycle_count);
        end
    endtask

    task automatic test_clamp();
        int e0;
        drive_start(MAXV + 1, e0);
        push_run(e0, MAXV + 1, MAXV + 1, 0);
        repeat (MAXV + LAT + 10) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL clamp %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL clamp %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (cycle_count !== 32'(MAXV + LAT)) begin
            failures++;
            $display("FAIL clamp_count got=%0d want=%0d", cycle_count, MAXV + LAT);
        end
    endtask

`ifdef ATS_STALL_EN
    task automatic test_stall();
        int e0;
        drive_start(4, e0);
        push_run(e0, 4, 2, 3);
        repeat (2) @(negedge pll_clock);
        stall = 1'b1;
        repeat (3) @(negedge pll_clock);
        stall = 1'b0;
        repeat (3) @(negedge pll_clock);
        stall = 1'b1;
        repeat (2) @(negedge pll_clock);
        stall = 1'b0;
        repeat (15) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL stall %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL stall %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        checks++;
        if (cycle_count !== 32'(4 + LAT + 3)) begin
            failures++;
            $display("FAIL stall_count got=%0d want=%0d", cycle_count, 4 + LAT + 3);
        end
    endtask
`endif

    task automatic test_async_reset();
        int e0;
        drive_start(6, e0);
        for (int k = 0; k < 6; k++)
            exp_q[0].push_back(ev_t'{32'(e0 + 1 + k), 32'(k % LANES), 32'(k / LANES)});
        for (int k = 0; k < 3; k++)
            exp_q[1].push_back(ev_t'{32'(e0 + 1 + k + LAT), 32'(k % LANES), 32'(k / LANES)});
        repeat (8) @(negedge pll_clock);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, aborted, r_en, w_en, cycle_count} !== 37'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%0d want=0/0", {busy, done, aborted, r_en, w_en}, cycle_count);
        end
        repeat (2) @(negedge pll_clock);
        resetn = 1'b1;
        repeat (15) @(negedge pll_clock);
        for (int q = 0; q < 3; q++) begin
            checks++;
            if (obs_q[q].size() - rd[q] != exp_q[q].size()) begin
                failures++;
                $display("FAIL async %s_count got=%0d want=%0d", kn[q], obs_q[q].size() - rd[q], exp_q[q].size());
            end
            for (int i = 0; i < exp_q[q].size(); i++) begin
                checks++;
                if (rd[q] + i >= obs_q[q].size() || obs_q[q][rd[q] + i] !== exp_q[q][i]) begin
                    failures++;
                    $display("FAIL async %s[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", kn[q], i,
                             obs_q[q][rd[q] + i].cyc, obs_q[q][rd[q] + i].a, obs_q[q][rd[q] + i].b,
                             exp_q[q][i].cyc, exp_q[q][i].a, exp_q[q][i].b);
                end
            end
            rd[q] = obs_q[q].size();
            exp_q[q].delete();
        end
        test_basic("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_zero();
        test_abort();
        test_restart();
        test_clamp();
`ifdef ATS_STALL_EN
        test_stall();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
